// File: rtl/traffic_pkg.sv
// Shared types for the junction controller: FSM state, approach direction and lamp triplet.
package traffic_pkg;

  typedef enum logic [3:0] {
    NS_RED_AMBER = 4'd0,
    NS_GREEN     = 4'd1,
    NS_AMBER     = 4'd2,
    ALL_RED_A    = 4'd3,
    EW_RED_AMBER = 4'd4,
    EW_GREEN     = 4'd5,
    EW_AMBER     = 4'd6,
    ALL_RED_B    = 4'd7,
    PED_WALK     = 4'd8
  } junction_state_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  typedef struct packed {
    logic red;
    logic amber;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_RED       = lamp_t'(3'b100);
  localparam lamp_t LAMP_RED_AMBER = lamp_t'(3'b110);
  localparam lamp_t LAMP_AMBER     = lamp_t'(3'b010);
  localparam lamp_t LAMP_GREEN     = lamp_t'(3'b001);

  // North-south lamp set as a function of the controller state.
  function automatic lamp_t ns_lamp(junction_state_e s);
    case (s)
      NS_RED_AMBER: return LAMP_RED_AMBER;
      NS_GREEN:     return LAMP_GREEN;
      NS_AMBER:     return LAMP_AMBER;
      default:      return LAMP_RED;
    endcase
  endfunction

  // East-west lamp set as a function of the controller state.
  function automatic lamp_t ew_lamp(junction_state_e s);
    case (s)
      EW_RED_AMBER: return LAMP_RED_AMBER;
      EW_GREEN:     return LAMP_GREEN;
      EW_AMBER:     return LAMP_AMBER;
      default:      return LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase elapsed counter: clears synchronously on a state change, flags the last cycle of a phase.
module phase_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] last_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign done_c_o = (cnt_q == last_i);

endmodule

// File: rtl/junction_controller.sv
// Two-approach junction sequencer with all-red clearance and a latched pedestrian walk phase.
// Define JUNCTION_PED_CUT_EN to let a pending request shorten green down to MIN_GREEN_CYCLES.
module junction_controller
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_CYCLES     = 6,
  parameter int unsigned AMBER_CYCLES     = 2,
  parameter int unsigned RED_AMBER_CYCLES = 2,
  parameter int unsigned ALL_RED_CYCLES   = 1,
  parameter int unsigned WALK_CYCLES      = 4,
  parameter int unsigned MIN_GREEN_CYCLES = 3,
  parameter int unsigned CNT_W            = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ped_req_i,
  output logic ns_red_o,
  output logic ns_amber_o,
  output logic ns_green_o,
  output logic ew_red_o,
  output logic ew_amber_o,
  output logic ew_green_o,
  output logic walk_o,
  output logic ped_wait_o
);

  localparam logic [CNT_W-1:0] GREEN_LAST     = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] AMBER_LAST     = CNT_W'(AMBER_CYCLES - 1);
  localparam logic [CNT_W-1:0] RED_AMBER_LAST = CNT_W'(RED_AMBER_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALL_RED_LAST   = CNT_W'(ALL_RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] WALK_LAST      = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_GREEN_LAST = CNT_W'(MIN_GREEN_CYCLES - 1);

`ifdef JUNCTION_PED_CUT_EN
  localparam bit CUT_EN = 1'b1;
`else
  localparam bit CUT_EN = 1'b0;
`endif

  junction_state_e  state_q, state_d;
  dir_e             next_dir_q, next_dir_d;
  logic             pend_q, pend_d;
  lamp_t            ns_lamp_q, ew_lamp_q;
  logic             walk_q;
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] phase_last_c;
  logic             phase_done_c;
  logic             green_cut_c;
  logic             state_chg_c;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (state_chg_c),
    .last_i   (phase_last_c),
    .cnt_o    (elapsed),
    .done_c_o (phase_done_c)
  );

  // Last elapsed value of the current phase.
  always_comb begin
    phase_last_c = ALL_RED_LAST;
    case (state_q)
      NS_RED_AMBER, EW_RED_AMBER: phase_last_c = RED_AMBER_LAST;
      NS_GREEN, EW_GREEN:         phase_last_c = GREEN_LAST;
      NS_AMBER, EW_AMBER:         phase_last_c = AMBER_LAST;
      PED_WALK:                   phase_last_c = WALK_LAST;
      default:                    phase_last_c = ALL_RED_LAST;
    endcase
  end

  assign green_cut_c = CUT_EN && pend_q && (elapsed >= MIN_GREEN_LAST);

  // Next-state, next-direction and pedestrian latch.
  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    case (state_q)
      NS_RED_AMBER: if (phase_done_c) state_d = NS_GREEN;
      NS_GREEN:     if (phase_done_c || green_cut_c) state_d = NS_AMBER;
      NS_AMBER:     if (phase_done_c) state_d = ALL_RED_A;
      ALL_RED_A: begin
        if (phase_done_c) begin
          next_dir_d = DIR_EW;
          state_d    = pend_q ? PED_WALK : EW_RED_AMBER;
        end
      end
      EW_RED_AMBER: if (phase_done_c) state_d = EW_GREEN;
      EW_GREEN:     if (phase_done_c || green_cut_c) state_d = EW_AMBER;
      EW_AMBER:     if (phase_done_c) state_d = ALL_RED_B;
      ALL_RED_B: begin
        if (phase_done_c) begin
          next_dir_d = DIR_NS;
          state_d    = pend_q ? PED_WALK : NS_RED_AMBER;
        end
      end
      PED_WALK: begin
        if (phase_done_c) state_d = (next_dir_q == DIR_EW) ? EW_RED_AMBER : NS_RED_AMBER;
      end
      default: begin
        state_d    = ALL_RED_B;
        next_dir_d = DIR_NS;
      end
    endcase

    // Entering the walk clears the request even if the button is still pressed.
    pend_d = pend_q;
    if (state_d == PED_WALK && state_q != PED_WALK) pend_d = 1'b0;
    else if (ped_req_i && state_q != PED_WALK)      pend_d = 1'b1;
  end

  assign state_chg_c = (state_d != state_q);

  // Lamps are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ALL_RED_B;
      next_dir_q <= DIR_NS;
      pend_q     <= 1'b0;
      ns_lamp_q  <= LAMP_RED;
      ew_lamp_q  <= LAMP_RED;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_dir_q <= next_dir_d;
      pend_q     <= pend_d;
      ns_lamp_q  <= ns_lamp(state_d);
      ew_lamp_q  <= ew_lamp(state_d);
      walk_q     <= (state_d == PED_WALK);
    end
  end

  assign ns_red_o   = ns_lamp_q.red;
  assign ns_amber_o = ns_lamp_q.amber;
  assign ns_green_o = ns_lamp_q.green;
  assign ew_red_o   = ew_lamp_q.red;
  assign ew_amber_o = ew_lamp_q.amber;
  assign ew_green_o = ew_lamp_q.green;
  assign walk_o     = walk_q;
  assign ped_wait_o = pend_q;

endmodule
